multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 op  in  6  IR[31:26] from the instruction register.
REQ-005 funct  in  6  IR[5:0] from the instruction register.
REQ-006 zero  in  1  ALU zero flag, same cycle.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 mem_req  out  1  memory access request; held until mem_ready.
REQ-009 iord  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 memwrite  out  1  memory write strobe.
REQ-011 irwrite  out  1  load instruction register.
REQ-012 pcen  out  1  PC register enable.
REQ-013 regdst  out  1  write register: 0 rt, 1 rd.
REQ-014 memtoreg  out  1  writeback data: 0 ALUOut, 1 memory data.
REQ-015 regwrite  out  1  register file write enable.
REQ-016 alusrca  out  1  ALU A: 0 PC, 1 register A.
REQ-017 alusrcb  out  2  ALU B: 00 register B, 01 constant 4, 10 signimm, 11 signimm<<2.
REQ-018 pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-019 aluctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-020 instr_done  out  1  one-cycle pulse in the final state of each instruction.
REQ-021 illegal  out  1  one-cycle pulse when an unsupported op or R-type funct is decoded.

Function
REQ-022 The block SHALL be a Moore FSM; outputs SHALL decode from the state only, except that pcen, irwrite and state advance also depend on mem_ready and zero as stated below.
REQ-023 The states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB and JEX; any output not listed for a state SHALL be 0.
REQ-024 FETCH SHALL drive mem_req=1, iord=0, alusrca=0, alusrcb=01, aluctrl=add and pcsrc=00, with irwrite=pcen=mem_ready; it SHALL advance to DECODE only when mem_ready=1 and hold otherwise.
REQ-025 DECODE SHALL drive alusrca=0, alusrcb=11 and aluctrl=add; it SHALL branch on op: lw/sw (100011/101011)->MEMADR, R (000000) with funct add/sub/and/or/slt (100000/100010/100100/100101/101010)->RTYPEEX, beq (000100)->BEQEX, addi (001000)->ADDIEX, j (000010)->JEX, otherwise->FETCH with illegal=1.
REQ-026 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluctrl=add; it SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-027 MEMRD SHALL drive mem_req=1 and iord=1, holding until mem_ready=1 and then moving to MEMWB.
REQ-028 MEMWB SHALL drive regdst=0, memtoreg=1, regwrite=1 and instr_done=1, then go to FETCH.
REQ-029 MEMWR SHALL drive mem_req=1, iord=1 and memwrite=1, holding until mem_ready=1; the mem_ready cycle SHALL also assert instr_done, then go to FETCH.
REQ-030 RTYPEEX SHALL drive alusrca=1, alusrcb=00 and aluctrl from funct; RTYPEWB SHALL drive regdst=1, memtoreg=0, regwrite=1 and instr_done=1.
REQ-031 BEQEX SHALL drive alusrca=1, alusrcb=00, aluctrl=sub, pcsrc=01, pcen=zero and instr_done=1.
REQ-032 ADDIEX SHALL drive alusrca=1, alusrcb=10 and aluctrl=add; ADDIWB SHALL drive regdst=0, memtoreg=0, regwrite=1 and instr_done=1.
REQ-033 JEX SHALL drive pcsrc=10, pcen=1 and instr_done=1.
REQ-034 With mem_ready tied high, latency from FETCH SHALL be: lw 5 cycles, sw 4, R 4, addi 4, beq 3, j 3; each mem_ready=0 cycle SHALL add exactly one cycle.
REQ-035 While any memory wait is in progress, regwrite, irwrite and pcen SHALL stay 0; the PC SHALL increment exactly once per fetch.

Reset
REQ-036 rst_n=0 SHALL force the state to FETCH immediately and SHALL gate every output to 0 while it is asserted.
REQ-037 Reset asserted mid-instruction SHALL abandon that instruction with no further regwrite, memwrite or pcen; fetch SHALL restart on the first rising clk edge after rst_n goes high.

Structure
REQ-038 A shared package SHALL hold the opcode and funct constants, the aluctrl codes, the alusrcb and pcsrc encodings, and the state enumeration.
REQ-039 The funct-to-aluctrl mapping SHALL be the existing aludec sub-module, driven with the R-type aluop in RTYPEEX; everything else SHALL be in-module.

Verification
REQ-040 Test 1: with mem_ready=1, issue add (op 000000, funct 100000) -> state sequence FETCH, DECODE, RTYPEEX, RTYPEWB; aluctrl=010 in RTYPEEX; regwrite=1 and regdst=1 in cycle 4.
REQ-041 Test 2: issue lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMRD -> completes in 10 cycles; pcen and irwrite pulse exactly once.
REQ-042 Test 3: issue beq twice, first with zero=1 and then with zero=0 -> pcen=1 and pcsrc=01 in BEQEX for the first only; instr_done in cycle 3 for both.
REQ-043 Test 4: issue op 111111, then R-type funct 000000 -> illegal pulses in DECODE, no regwrite or memwrite, next state FETCH.
REQ-044 Test 5: assert rst_n=0 during MEMWR -> memwrite drops to 0 asynchronously; after release, the first cycle is FETCH with mem_req=1 and iord=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller:
// opcodes, functs, ALU codes, mux selects and FSM states.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
    S_JEX
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the controller's aluop and the
// instruction funct field onto an ALU operation code.
module multicycle_controller_aludec
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluctrl
);

  always_comb begin
    aluctrl = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: aluctrl = ALU_ADD;
      ALUOP_SUB: aluctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          F_ADD:   aluctrl = ALU_ADD;
          F_SUB:   aluctrl = ALU_SUB;
          F_AND:   aluctrl = ALU_AND;
          F_OR:    aluctrl = ALU_OR;
          F_SLT:   aluctrl = ALU_SLT;
          default: aluctrl = ALU_ADD;
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS-like datapath
// with a handshaked memory (mem_req held until mem_ready).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluctrl,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state;
  state_t     state_nxt;
  aluop_t     aluop;
  logic [2:0] dec_ctrl;
  ctrl_t      c;

  logic is_mem;
  logic is_r;
  logic is_beq;
  logic is_addi;
  logic is_j;

  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_RTYPE) && funct_ok(funct);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);

  multicycle_controller_aludec u_aludec (
    .aluop   (aluop),
    .funct   (funct),
    .aluctrl (dec_ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aluop     = ALUOP_ADD;
    c         = '0;
    unique case (state)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.pcsrc   = PC_ALU;
        c.aluctrl = dec_ctrl;
        c.irwrite = mem_ready;
        c.pcen    = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluctrl = dec_ctrl;
        unique case (1'b1)
          is_mem:  state_nxt = S_MEMADR;
          is_r:    state_nxt = S_RTYPEEX;
          is_beq:  state_nxt = S_BEQEX;
          is_addi: state_nxt = S_ADDIEX;
          is_j:    state_nxt = S_JEX;
          default: begin
            c.illegal = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluctrl = dec_ctrl;
        state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_req    = 1'b1;
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.instr_done = mem_ready;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_RTYPEEX: begin
        aluop     = ALUOP_FUNCT;
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluctrl = dec_ctrl;
        state_nxt = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQEX: begin
        aluop        = ALUOP_SUB;
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_REG;
        c.aluctrl    = dec_ctrl;
        c.pcsrc      = PC_ALUOUT;
        c.pcen       = zero;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluctrl = dec_ctrl;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JEX: begin
        c.pcsrc      = PC_JUMP;
        c.pcen       = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign mem_req    = c.mem_req    & rst_n;
  assign iord       = c.iord       & rst_n;
  assign memwrite   = c.memwrite   & rst_n;
  assign irwrite    = c.irwrite    & rst_n;
  assign pcen       = c.pcen       & rst_n;
  assign regdst     = c.regdst     & rst_n;
  assign memtoreg   = c.memtoreg   & rst_n;
  assign regwrite   = c.regwrite   & rst_n;
  assign alusrca    = c.alusrca    & rst_n;
  assign alusrcb    = c.alusrcb    & {2{rst_n}};
  assign pcsrc      = c.pcsrc      & {2{rst_n}};
  assign aluctrl    = c.aluctrl    & {3{rst_n}};
  assign instr_done = c.instr_done & rst_n;
  assign illegal    = c.illegal    & rst_n;

endmodule
